// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the boot loader.
// The loader connects through the master modport; the stream source and memory model use slave.
interface imem_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [31:0] imem_waddress;
   logic [31:0] imem_datain;
   logic        imem_wr;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_waddress, imem_datain, imem_wr
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_waddress, imem_datain, imem_wr
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses [N_lo, N_hi, 4*N payload bytes, XOR checksum]
// from a byte stream, writes each little-endian word, and holds the CPU until the image verifies.
module imem_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [15:0] MAX_WORDS = 16'd16384
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          restart,
   imem_loader_if.master bus,
   output logic          cpu_hold,
   output logic          load_done,
   output logic          load_error,
   output logic [15:0]   word_count
);

   typedef enum logic [2:0] {
      S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_n;
   logic [15:0] r_idx;
   logic [1:0]  r_k;
   logic [31:0] r_asm;
   logic [7:0]  r_xor;
   logic [31:0] r_waddr;

   logic        w_ready;
   logic        w_accept;
   logic [15:0] w_n_hdr;
   logic [15:0] w_idx_next;

   assign w_accept   = bus.rx_valid && w_ready;
   assign w_n_hdr    = {bus.rx_data, r_n[7:0]};
   assign w_idx_next = r_idx + 16'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_HDR_LO;
      end else begin
         r_state <= w_state_next;
      end
   end

   // restart overrides any transition, including one caused by a byte accepted this cycle
   always_comb begin
      w_state_next = r_state;
      if (restart) begin
         w_state_next = S_HDR_LO;
      end else begin
         case (r_state)
            S_HDR_LO:  if (w_accept) w_state_next = S_HDR_HI;
            S_HDR_HI:  if (w_accept) begin
                          if (w_n_hdr > MAX_WORDS)  w_state_next = S_ERROR;
                          else if (w_n_hdr == 16'd0) w_state_next = S_CHECK;
                          else                      w_state_next = S_PAYLOAD;
                       end
            S_PAYLOAD: if (w_accept && r_k == 2'd3) w_state_next = S_WRITE;
            S_WRITE:   w_state_next = (w_idx_next == r_n) ? S_CHECK : S_PAYLOAD;
            S_CHECK:   if (w_accept) w_state_next = (bus.rx_data == r_xor) ? S_DONE : S_ERROR;
            S_DONE:    w_state_next = S_DONE;
            S_ERROR:   w_state_next = S_ERROR;
            default:   w_state_next = S_HDR_LO;
         endcase
      end
   end

   always_comb begin
      w_ready     = 1'b0;
      bus.imem_wr = 1'b0;
      cpu_hold    = 1'b1;
      load_done   = 1'b0;
      load_error  = 1'b0;
      case (r_state)
         S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_CHECK: w_ready = 1'b1;
         S_WRITE: bus.imem_wr = 1'b1;
         S_DONE: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
         end
         S_ERROR: load_error = 1'b1;
         default: ;
      endcase
   end

   // The assembly register doubles as the registered write data; no byte is accepted during WRITE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_n     <= '0;
         r_idx   <= '0;
         r_k     <= '0;
         r_asm   <= '0;
         r_xor   <= '0;
         r_waddr <= ADDR_BASE;
      end else if (restart) begin
         r_n     <= '0;
         r_idx   <= '0;
         r_k     <= '0;
         r_asm   <= '0;
         r_xor   <= '0;
         r_waddr <= ADDR_BASE;
      end else begin
         case (r_state)
            S_HDR_LO:  if (w_accept) r_n[7:0]  <= bus.rx_data;
            S_HDR_HI:  if (w_accept) r_n[15:8] <= bus.rx_data;
            S_PAYLOAD: if (w_accept) begin
                          r_asm[{r_k, 3'b000} +: 8] <= bus.rx_data;
                          r_xor <= r_xor ^ bus.rx_data;
                          r_k   <= r_k + 2'd1;
                       end
            S_WRITE: begin
               r_idx   <= w_idx_next;
               r_waddr <= r_waddr + 32'd4;
            end
            default: ;
         endcase
      end
   end

   assign bus.rx_ready      = w_ready;
   assign bus.imem_waddress = r_waddr;
   assign bus.imem_datain   = r_asm;
   assign word_count        = r_idx;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads against a queue-based model of the expected memory writes
// and final status of imem_loader.
module tb_imem_loader;
   localparam logic [31:0] ABASE = 32'h0000_0000;
   localparam logic [15:0] MAXW  = 16'd16384;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        restart = 1'b0;
   logic        cpu_hold, load_done, load_error;
   logic [15:0] word_count;

   imem_loader_if bus ();

   imem_loader #(.ADDR_BASE(ABASE), .MAX_WORDS(MAXW)) dut (
      .clock      (clock),
      .reset      (reset),
      .restart    (restart),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         got[$];
   logic [31:0] img[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          ready_viol = 0;

   always @(negedge clock) begin
      if (bus.imem_wr === 1'b1) begin
         got.push_back('{bus.imem_waddress, bus.imem_datain});
         if (bus.rx_ready !== 1'b0) ready_viol++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offers one byte starting at a falling edge; returns on the falling edge after it is taken.
   task automatic send(input logic [7:0] b, input bit rnd);
      int guard = 0;
      if (rnd) begin
         repeat ($urandom_range(0, 3)) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clock);
         end
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (bus.rx_ready !== 1'b1 && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      n_tests++;
      assert (guard < 50) else begin
         n_fail++;
         $error("FAIL rx_ready_timeout observed=%0d expected=<50 byte=%h", guard, b);
      end
      @(negedge clock);
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
      @(negedge clock);
      got.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rx_ready"},   32'(bus.rx_ready),      32'd1);
      chk({tag, "_imem_wr"},    32'(bus.imem_wr),       32'd0);
      chk({tag, "_waddress"},   bus.imem_waddress,      ABASE);
      chk({tag, "_datain"},     bus.imem_datain,        32'd0);
      chk({tag, "_cpu_hold"},   32'(cpu_hold),          32'd1);
      chk({tag, "_load_done"},  32'(load_done),         32'd0);
      chk({tag, "_load_error"}, 32'(load_error),        32'd0);
      chk({tag, "_word_count"}, 32'(word_count),        32'd0);
   endtask

   // Loads img[0..n-1] with a correct or corrupted checksum and checks writes and final status.
   task automatic run_image(input string tag, input logic [15:0] n, input bit bad_ck, input bit rnd);
      logic [7:0] ck = 8'h00;
      logic [7:0] b;
      pulse_restart();
      send(n[7:0], rnd);
      send(n[15:8], rnd);
      if (n > MAXW) begin
         chk({tag, "_err"},    32'(load_error),   32'd1);
         chk({tag, "_ready"},  32'(bus.rx_ready), 32'd0);
         chk({tag, "_hold"},   32'(cpu_hold),     32'd1);
         chk({tag, "_nwr"},    32'(got.size()),   32'd0);
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         for (int j = 0; j < 4; j++) begin
            b  = img[i][8*j +: 8];
            ck = ck ^ b;
            send(b, rnd);
         end
      end
      send(bad_ck ? (ck ^ 8'hA5) : ck, rnd);
      chk({tag, "_nwr"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < int'(n) && i < got.size(); i++) begin
         chk({tag, "_addr"}, got[i].a, ABASE + 32'(4 * i));
         chk({tag, "_data"}, got[i].d, img[i]);
      end
      chk({tag, "_done"},  32'(load_done),  32'(!bad_ck));
      chk({tag, "_err"},   32'(load_error), 32'(bad_ck));
      chk({tag, "_hold"},  32'(cpu_hold),   32'(bad_ck));
      chk({tag, "_count"}, 32'(word_count), 32'(n));
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #12;
      check_reset_vals("in_reset");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_vals("after_reset");

      img = '{32'h0000_0013, 32'h0040_0093};
      run_image("n2_good", 16'd2, 1'b0, 1'b0);
      run_image("n2_badck", 16'd2, 1'b1, 1'b0);

      img.delete();
      run_image("n0_good", 16'd0, 1'b0, 1'b0);
      run_image("n0_bad", 16'd0, 1'b1, 1'b0);
      run_image("n_ffff", 16'hFFFF, 1'b0, 1'b0);
      run_image("n_max_p1", MAXW + 16'd1, 1'b0, 1'b0);

      img = '{32'($urandom)};
      run_image("n1_gaps", 16'd1, 1'b0, 1'b1);

      // Abandon an image two payload bytes in; the restart inside run_image must discard them
      pulse_restart();
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'hEE, 1'b0);
      send(8'hDD, 1'b0);
      img = '{32'hCAFE_F00D};
      run_image("restart_mid", 16'd1, 1'b0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         int n = $urandom_range(1, 6);
         img.delete();
         for (int i = 0; i < n; i++) img.push_back(32'($urandom));
         run_image("rand", 16'(n), ($urandom_range(0, 3) == 0), 1'b1);
      end

      chk("ready_low_in_write", 32'(ready_viol), 32'd0);

      // Async reset while a write is on the bus
      pulse_restart();
      send(8'h02, 1'b0);
      send(8'h00, 1'b0);
      for (int j = 0; j < 4; j++) send(8'(8'h10 + j), 1'b0);
      chk("pre_reset_wr", 32'(bus.imem_wr), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_reset_vals("async_reset");
      @(negedge clock);
      reset = 1'b0;
      got.delete();
      repeat (10) @(negedge clock);
      chk("post_reset_nwr", 32'(got.size()), 32'd0);
      check_reset_vals("post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
